// File: rtl/bsram_sd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bsram_sd_sequencer
// Description : Moves backup RAM between the cartridge BSRAM and the SD save
//               image, one 512-byte sector per sd_rd/sd_wr handshake. Owns
//               bk_ena, tracks BSRAM dirtiness and holds the core in reset
//               (bk_loading) while a load is running.
// Revision    : 1.0 - initial release
// ============================================================================
module bsram_sd_sequencer #(
    parameter int BSRAM_BITS = 16,
    parameter int LBA_W      = 32
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ioctl_download,
    input  logic             img_mounted,
    input  logic             img_readonly,
    input  logic [63:0]      img_size,
    input  logic [23:0]      ram_mask,
    input  logic             load_req,
    input  logic             save_req,
    input  logic             autosave,
    input  logic             bsram_wr,
    input  logic             sd_ack,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    output logic             bk_ena,
    output logic             bk_loading,
    output logic             busy,
    output logic             dirty
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_XFER = 2'd2;

    // Highest sector the BSRAM port can address at all.
    localparam logic [LBA_W-1:0] c_MAX_LBA = LBA_W'((64'd1 << (BSRAM_BITS - 9)) - 64'd1);
    localparam logic [LBA_W-1:0] c_ONE     = {{(LBA_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state, w_state_nxt;
    logic [LBA_W-1:0] r_sd_lba, w_lba_nxt;
    logic             r_sd_rd, w_rd_nxt;
    logic             r_sd_wr, w_wr_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_bk_loading, w_loading_nxt;
    logic             r_mode_load, w_mode_nxt;
    logic             r_bk_ena;
    logic             r_dirty;
    logic             r_abort;
    logic             r_armed;
    logic             r_dl_d, r_load_d, r_save_d;
    logic             r_ack, r_ack_d;
    logic             w_save_start, w_load_done;

    // Edge detectors; sd_ack is only ever looked at through its registered copy.
    logic w_dl_rise, w_dl_fall, w_load_rise, w_save_rise, w_ack_rise, w_ack_fall;
    assign w_dl_rise   =  ioctl_download & ~r_dl_d;
    assign w_dl_fall   = ~ioctl_download &  r_dl_d;
    assign w_load_rise =  load_req & ~r_load_d;
    assign w_save_rise =  save_req & ~r_save_d;
    assign w_ack_rise  =  r_ack & ~r_ack_d;
    assign w_ack_fall  = ~r_ack &  r_ack_d;

    // An ack rise only counts once ack has been seen low inside REQ, so an ack
    // that was already high on entry must first fall and rise again.
    logic w_req_ack;
    assign w_req_ack = w_ack_rise & r_armed;

    // Load outranks save; the auto-load on download end outranks everything.
    logic w_start_load, w_start_save;
    assign w_start_load = r_bk_ena & (w_dl_fall | w_load_rise);
    assign w_start_save = r_bk_ena & ~w_start_load & (w_save_rise | (autosave & r_dirty));

    logic [LBA_W-1:0] w_last_lba;
    logic             w_done;
    assign w_last_lba = LBA_W'(ram_mask[23:9]);
    assign w_done     = (r_sd_lba >= w_last_lba) | (r_sd_lba >= c_MAX_LBA) | r_abort;

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_start_load | w_start_save) w_state_nxt = c_REQ;
            c_REQ:   if (w_req_ack) w_state_nxt = c_XFER;
            c_XFER:  if (w_ack_fall) w_state_nxt = w_done ? c_IDLE : c_REQ;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_lba_nxt     = r_sd_lba;
        w_rd_nxt      = r_sd_rd;
        w_wr_nxt      = r_sd_wr;
        w_busy_nxt    = r_busy;
        w_loading_nxt = r_bk_loading;
        w_mode_nxt    = r_mode_load;
        w_save_start  = 1'b0;
        w_load_done   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start_load | w_start_save) begin
                    w_lba_nxt     = '0;
                    w_busy_nxt    = 1'b1;
                    w_loading_nxt = w_start_load;
                    w_rd_nxt      = w_start_load;
                    w_wr_nxt      = ~w_start_load;
                    w_mode_nxt    = w_start_load;
                    w_save_start  = ~w_start_load;
                end
            end
            c_REQ: begin
                if (w_req_ack) begin
                    w_rd_nxt = 1'b0;
                    w_wr_nxt = 1'b0;
                end
            end
            c_XFER: begin
                if (w_ack_fall) begin
                    if (w_done) begin
                        w_busy_nxt    = 1'b0;
                        w_loading_nxt = 1'b0;
                        w_load_done   = r_mode_load & ~r_abort;
                    end else begin
                        w_lba_nxt = r_sd_lba + c_ONE;
                        w_rd_nxt  = r_mode_load;
                        w_wr_nxt  = ~r_mode_load;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output, edge, abort, dirty and bk_ena registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sd_lba     <= '0;
            r_sd_rd      <= 1'b0;
            r_sd_wr      <= 1'b0;
            r_busy       <= 1'b0;
            r_bk_loading <= 1'b0;
            r_mode_load  <= 1'b0;
            r_bk_ena     <= 1'b0;
            r_dirty      <= 1'b0;
            r_abort      <= 1'b0;
            r_armed      <= 1'b0;
            r_dl_d       <= 1'b0;
            r_load_d     <= 1'b0;
            r_save_d     <= 1'b0;
            r_ack        <= 1'b0;
            r_ack_d      <= 1'b0;
        end else begin
            r_sd_lba     <= w_lba_nxt;
            r_sd_rd      <= w_rd_nxt;
            r_sd_wr      <= w_wr_nxt;
            r_busy       <= w_busy_nxt;
            r_bk_loading <= w_loading_nxt;
            r_mode_load  <= w_mode_nxt;
            r_dl_d       <= ioctl_download;
            r_load_d     <= load_req;
            r_save_d     <= save_req;
            r_ack        <= sd_ack;
            r_ack_d      <= r_ack;
            r_armed      <= (r_state == c_REQ) & (r_armed | ~r_ack);
            // Abort lives only as long as the transfer it interrupts.
            r_abort      <= (w_state_nxt != c_IDLE) & (r_abort | (w_dl_rise & r_busy));

            if (w_dl_rise)
                r_bk_ena <= 1'b0;
            else if (ioctl_download & img_mounted & (img_size != 64'd0) & ~img_readonly)
                r_bk_ena <= |ram_mask;

            // A write in the same cycle as any clear keeps the RAM dirty.
            if (bsram_wr & ~r_bk_loading)
                r_dirty <= 1'b1;
            else if (w_dl_rise | w_save_start | w_load_done)
                r_dirty <= 1'b0;
        end
    end

    assign sd_lba     = r_sd_lba;
    assign sd_rd      = r_sd_rd;
    assign sd_wr      = r_sd_wr;
    assign bk_ena     = r_bk_ena;
    assign bk_loading = r_bk_loading;
    assign busy       = r_busy;
    assign dirty      = r_dirty;

endmodule
`default_nettype wire

// File: tb/tb_bsram_sd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsram_sd_sequencer
// Description : Self-checking bench for bsram_sd_sequencer with a randomized
//               hps_io sector responder and a sector-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsram_sd_sequencer;

    localparam int BSRAM_BITS = 16;
    localparam int LBA_W      = 32;
    localparam int CAP        = 1 << (BSRAM_BITS - 9);

    logic             clk_sys = 1'b0;
    logic             reset;
    logic             ioctl_download;
    logic             img_mounted;
    logic             img_readonly;
    logic [63:0]      img_size;
    logic [23:0]      ram_mask;
    logic             load_req;
    logic             save_req;
    logic             autosave;
    logic             bsram_wr;
    logic             sd_ack;
    logic [LBA_W-1:0] sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             bk_ena;
    logic             bk_loading;
    logic             busy;
    logic             dirty;

    int checks = 0;
    int errors = 0;

    bsram_sd_sequencer #(
        .BSRAM_BITS (BSRAM_BITS),
        .LBA_W      (LBA_W)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .img_mounted    (img_mounted),
        .img_readonly   (img_readonly),
        .img_size       (img_size),
        .ram_mask       (ram_mask),
        .load_req       (load_req),
        .save_req       (save_req),
        .autosave       (autosave),
        .bsram_wr       (bsram_wr),
        .sd_ack         (sd_ack),
        .sd_lba         (sd_lba),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .bk_ena         (bk_ena),
        .bk_loading     (bk_loading),
        .busy           (busy),
        .dirty          (dirty)
    );

    always #5 clk_sys = ~clk_sys;

    // hps_io responder: logs every sector request and acks it after random delays.
    logic [LBA_W-1:0] hs_lba_q[$];
    bit               hs_rd_q[$];
    int               proto_err = 0;
    bit               rsp_dropped;

    initial begin
        sd_ack = 1'b0;
        forever begin
            @(posedge clk_sys); #1;
            if (sd_rd || sd_wr) begin
                hs_lba_q.push_back(sd_lba);
                hs_rd_q.push_back(sd_rd);
                if (sd_rd && sd_wr) proto_err++;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk_sys); #1;
                    if (!(sd_rd || sd_wr)) proto_err++;
                end
                sd_ack = 1'b1;
                rsp_dropped = 1'b0;
                for (int i = 0; i < 40 && !rsp_dropped; i++) begin
                    @(posedge clk_sys); #1;
                    if (!(sd_rd || sd_wr)) rsp_dropped = 1'b1;
                end
                if (!rsp_dropped) proto_err++;
                repeat ($urandom_range(0, 3)) @(posedge clk_sys);
                #1 sd_ack = 1'b0;
            end
        end
    end

    // Reference model: sectors per transfer and whether a mount enables BSRAM.
    function automatic int ref_sectors(input logic [23:0] mask);
        int last;
        last = int'(mask >> 9);
        if (last > CAP - 1) last = CAP - 1;
        return last + 1;
    endfunction

    function automatic bit ref_ena(input bit ro, input logic [63:0] size, input logic [23:0] mask);
        return !ro && (size != 64'd0) && (mask != 24'd0);
    endfunction

    // Number of logged handshakes that deviate from lba 0..n-1 of the given direction.
    function automatic int seq_errors(input int n, input bit rd);
        int bad;
        bad = 0;
        for (int i = 0; i < hs_lba_q.size(); i++) begin
            if (i >= n || hs_lba_q[i] !== LBA_W'(i) || hs_rd_q[i] !== rd) bad++;
        end
        return bad;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_log();
        hs_lba_q.delete();
        hs_rd_q.delete();
    endtask

    task automatic wait_idle(input int bound, input bit exp_loading, output bit ok, output bit held);
        ok   = 1'b0;
        held = 1'b1;
        for (int i = 0; i < bound; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (bk_loading !== exp_loading) held = 1'b0;
            tick(1);
        end
    endtask

    task automatic mount(input bit ro, input logic [63:0] size, input logic [23:0] mask);
        ioctl_download = 1'b1;
        ram_mask       = mask;
        tick(2);
        img_readonly = ro;
        img_size     = size;
        img_mounted  = 1'b1;
        tick(1);
        img_mounted  = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        checks++;
        if ({sd_lba, sd_rd, sd_wr, bk_ena, bk_loading, busy, dirty} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got lba=%0d rd=%b wr=%b ena=%b ld=%b busy=%b dirty=%b, want all 0",
                     sd_lba, sd_rd, sd_wr, bk_ena, bk_loading, busy, dirty);
        end
    endtask

    task automatic test_autoload();
        bit ok, held;
        int p0;
        p0 = proto_err;
        mount(1'b0, 64'd8192, 24'h1FFF);
        checks++;
        if (bk_ena !== 1'b1) begin
            errors++;
            $display("FAIL autoload_ena: bk_ena=%b want 1", bk_ena);
        end
        clear_log();
        ioctl_download = 1'b0;
        tick(1);
        checks++;
        if ({sd_rd, sd_wr, bk_loading, busy, sd_lba} !== {4'b1011, 32'd0}) begin
            errors++;
            $display("FAIL autoload_start: rd=%b wr=%b ld=%b busy=%b lba=%0d want 1 0 1 1 0",
                     sd_rd, sd_wr, bk_loading, busy, sd_lba);
        end
        wait_idle(3000, 1'b1, ok, held);
        checks++;
        if (!ok || !held) begin
            errors++;
            $display("FAIL autoload_run: finished=%b loading_held=%b want 1 1", ok, held);
        end
        checks++;
        if (hs_lba_q.size() !== 16 || seq_errors(16, 1'b1) !== 0) begin
            errors++;
            $display("FAIL autoload_seq: sectors=%0d bad=%0d want 16 0", hs_lba_q.size(), seq_errors(16, 1'b1));
        end
        checks++;
        if ({bk_loading, sd_rd, proto_err - p0} !== {2'b00, 32'd0}) begin
            errors++;
            $display("FAIL autoload_end: ld=%b rd=%b proto=%0d want 0 0 0", bk_loading, sd_rd, proto_err - p0);
        end
    endtask

    task automatic test_save();
        bit ok, held;
        mount(1'b0, 64'd2048, 24'h7FF);
        ioctl_download = 1'b0;
        tick(1);
        wait_idle(2000, 1'b1, ok, held);
        bsram_wr = 1'b1;
        tick(1);
        bsram_wr = 1'b0;
        tick(1);
        checks++;
        if (dirty !== 1'b1) begin
            errors++;
            $display("FAIL save_dirty_set: dirty=%b want 1", dirty);
        end
        clear_log();
        save_req = 1'b1;
        tick(1);
        checks++;
        if ({sd_wr, sd_rd, dirty, busy, bk_loading, sd_lba} !== {5'b10010, 32'd0}) begin
            errors++;
            $display("FAIL save_start: wr=%b rd=%b dirty=%b busy=%b ld=%b lba=%0d want 1 0 0 1 0 0",
                     sd_wr, sd_rd, dirty, busy, bk_loading, sd_lba);
        end
        wait_idle(2000, 1'b0, ok, held);
        checks++;
        if (!ok || !held || hs_lba_q.size() !== 4 || seq_errors(4, 1'b0) !== 0) begin
            errors++;
            $display("FAIL save_seq: finished=%b noload=%b sectors=%0d bad=%0d want 1 1 4 0",
                     ok, held, hs_lba_q.size(), seq_errors(4, 1'b0));
        end
        save_req = 1'b0;
        tick(1);
    endtask

    task automatic test_autosave();
        bit ok, held;
        int busy_cnt;
        bsram_wr = 1'b1;
        tick(1);
        bsram_wr = 1'b0;
        clear_log();
        autosave = 1'b1;
        tick(1);
        autosave = 1'b0;
        wait_idle(2000, 1'b0, ok, held);
        checks++;
        if (!ok || hs_lba_q.size() !== 4 || seq_errors(4, 1'b0) !== 0 || dirty !== 1'b0) begin
            errors++;
            $display("FAIL autosave_dirty: finished=%b sectors=%0d bad=%0d dirty=%b want 1 4 0 0",
                     ok, hs_lba_q.size(), seq_errors(4, 1'b0), dirty);
        end
        clear_log();
        autosave = 1'b1;
        tick(1);
        autosave = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy || sd_wr) busy_cnt++;
            tick(1);
        end
        checks++;
        if (busy_cnt !== 0 || hs_lba_q.size() !== 0) begin
            errors++;
            $display("FAIL autosave_clean: busy_cycles=%0d sectors=%0d want 0 0", busy_cnt, hs_lba_q.size());
        end
        // A write landing mid-save must survive the save.
        bsram_wr = 1'b1;
        tick(1);
        bsram_wr = 1'b0;
        clear_log();
        autosave = 1'b1;
        tick(1);
        autosave = 1'b0;
        tick(3);
        bsram_wr = 1'b1;
        tick(1);
        bsram_wr = 1'b0;
        wait_idle(2000, 1'b0, ok, held);
        checks++;
        if (!ok || hs_lba_q.size() !== 4 || dirty !== 1'b1) begin
            errors++;
            $display("FAIL autosave_midwrite: finished=%b sectors=%0d dirty=%b want 1 4 1",
                     ok, hs_lba_q.size(), dirty);
        end
    endtask

    task automatic test_priority();
        bit ok, held;
        int busy_cnt;
        clear_log();
        load_req = 1'b1;
        save_req = 1'b1;
        tick(1);
        checks++;
        if ({sd_rd, sd_wr, bk_loading, busy} !== 4'b1011) begin
            errors++;
            $display("FAIL prio_load: rd=%b wr=%b ld=%b busy=%b want 1 0 1 1", sd_rd, sd_wr, bk_loading, busy);
        end
        save_req = 1'b0;
        tick(1);
        save_req = 1'b1;
        bsram_wr = 1'b1;
        tick(1);
        bsram_wr = 1'b0;
        checks++;
        if ({busy, bk_loading, sd_wr} !== 3'b110) begin
            errors++;
            $display("FAIL prio_save_during_load: busy=%b ld=%b wr=%b want 1 1 0", busy, bk_loading, sd_wr);
        end
        wait_idle(2000, 1'b1, ok, held);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_cnt++;
            tick(1);
        end
        checks++;
        if (!ok || !held || busy_cnt !== 0 || hs_lba_q.size() !== 4 || seq_errors(4, 1'b1) !== 0 || dirty !== 1'b0) begin
            errors++;
            $display("FAIL prio_seq: finished=%b held=%b later_busy=%0d sectors=%0d bad=%0d dirty=%b want 1 1 0 4 0 0",
                     ok, held, busy_cnt, hs_lba_q.size(), seq_errors(4, 1'b1), dirty);
        end
        load_req = 1'b0;
        save_req = 1'b0;
        tick(1);
    endtask

    task automatic test_readonly();
        int busy_cnt;
        mount(1'b1, 64'd8192, 24'h7FF);
        checks++;
        if (bk_ena !== 1'b0) begin
            errors++;
            $display("FAIL ro_ena: bk_ena=%b want 0", bk_ena);
        end
        clear_log();
        ioctl_download = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            load_req = (i >= 3);
            save_req = (i >= 6);
            bsram_wr = (i == 9);
            autosave = (i == 12);
            tick(1);
            if (busy || sd_rd || sd_wr) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== 0 || hs_lba_q.size() !== 0 || dirty !== 1'b1) begin
            errors++;
            $display("FAIL ro_no_xfer: busy_cycles=%0d sectors=%0d dirty=%b want 0 0 1", busy_cnt, hs_lba_q.size(), dirty);
        end
        load_req = 1'b0;
        save_req = 1'b0;
        mount(1'b0, 64'd0, 24'h7FF);
        checks++;
        if (bk_ena !== 1'b0) begin
            errors++;
            $display("FAIL size0_ena: bk_ena=%b want 0", bk_ena);
        end
        mount(1'b0, 64'd8192, 24'h000000);
        checks++;
        if (bk_ena !== 1'b0) begin
            errors++;
            $display("FAIL mask0_ena: bk_ena=%b want 0", bk_ena);
        end
        ioctl_download = 1'b0;
        tick(4);
    endtask

    task automatic test_abort();
        bit ok, held, got;
        int p0;
        p0 = proto_err;
        mount(1'b0, 64'd4096, 24'hFFF);
        bsram_wr = 1'b1;
        tick(1);
        bsram_wr = 1'b0;
        clear_log();
        ioctl_download = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            if (hs_lba_q.size() >= 3) got = 1'b1;
            else tick(1);
        end
        checks++;
        if (!got || dirty !== 1'b1) begin
            errors++;
            $display("FAIL abort_reach: reached_sector2=%b dirty=%b want 1 1", got, dirty);
        end
        ioctl_download = 1'b1;
        tick(1);
        checks++;
        if ({busy, bk_ena, dirty} !== 3'b100) begin
            errors++;
            $display("FAIL abort_flags: busy=%b ena=%b dirty=%b want 1 0 0", busy, bk_ena, dirty);
        end
        wait_idle(500, 1'b1, ok, held);
        checks++;
        if (!ok || hs_lba_q.size() !== 3 || sd_lba !== 32'd2 || bk_loading !== 1'b0 || dirty !== 1'b0 ||
            proto_err !== p0) begin
            errors++;
            $display("FAIL abort_end: finished=%b sectors=%0d lba=%0d ld=%b dirty=%b proto=%0d want 1 3 2 0 0 0",
                     ok, hs_lba_q.size(), sd_lba, bk_loading, dirty, proto_err - p0);
        end
        ioctl_download = 1'b0;
        tick(4);
        checks++;
        if (busy !== 1'b0 || hs_lba_q.size() !== 3) begin
            errors++;
            $display("FAIL abort_no_reload: busy=%b sectors=%0d want 0 3", busy, hs_lba_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        mount(1'b0, 64'd4096, 24'hFFF);
        clear_log();
        ioctl_download = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            if (hs_lba_q.size() >= 2) got = 1'b1;
            else tick(1);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (!got || {sd_lba, sd_rd, sd_wr, bk_ena, bk_loading, busy, dirty} !== '0) begin
            errors++;
            $display("FAIL reset_mid: reached=%b lba=%0d rd=%b wr=%b ena=%b ld=%b busy=%b dirty=%b want 1 and all 0",
                     got, sd_lba, sd_rd, sd_wr, bk_ena, bk_loading, busy, dirty);
        end
        tick(8);
        load_req = 1'b1;
        tick(3);
        checks++;
        if ({busy, bk_ena} !== 2'b00) begin
            errors++;
            $display("FAIL reset_no_ena: busy=%b ena=%b want 0 0", busy, bk_ena);
        end
        load_req = 1'b0;
        tick(8);
    endtask

    task automatic test_random();
        bit ok, held, ro, ena;
        logic [23:0] mask;
        int n;
        for (int it = 0; it < 6; it++) begin
            if (it == 0)      mask = 24'hFFFFFF;
            else if (it == 1) mask = 24'h0001FF;
            else              mask = 24'(($urandom_range(0, 12) << 9) | $urandom_range(0, 511));
            ro  = ($urandom_range(0, 3) == 0) && (it > 1);
            ena = ref_ena(ro, 64'd65536, mask);
            n   = ena ? ref_sectors(mask) : 0;
            mount(ro, 64'd65536, mask);
            checks++;
            if (bk_ena !== ena) begin
                errors++;
                $display("FAIL rand_ena[%0d]: mask=%h ro=%b bk_ena=%b want %b", it, mask, ro, bk_ena, ena);
            end
            clear_log();
            ioctl_download = 1'b0;
            tick(1);
            wait_idle(6000, 1'b1, ok, held);
            checks++;
            if (!ok || !held || hs_lba_q.size() !== n || seq_errors(n, 1'b1) !== 0) begin
                errors++;
                $display("FAIL rand_load[%0d]: mask=%h finished=%b held=%b sectors=%0d bad=%0d want 1 1 %0d 0",
                         it, mask, ok, held, hs_lba_q.size(), seq_errors(n, 1'b1), n);
            end
            clear_log();
            save_req = 1'b1;
            tick(1);
            wait_idle(6000, 1'b0, ok, held);
            checks++;
            if (!ok || !held || hs_lba_q.size() !== n || seq_errors(n, 1'b0) !== 0) begin
                errors++;
                $display("FAIL rand_save[%0d]: mask=%h finished=%b noload=%b sectors=%0d bad=%0d want 1 1 %0d 0",
                         it, mask, ok, held, hs_lba_q.size(), seq_errors(n, 1'b0), n);
            end
            save_req = 1'b0;
            tick(2);
        end
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        img_mounted    = 1'b0;
        img_readonly   = 1'b0;
        img_size       = 64'd0;
        ram_mask       = 24'd0;
        load_req       = 1'b0;
        save_req       = 1'b0;
        autosave       = 1'b0;
        bsram_wr       = 1'b0;
        test_reset();
        test_autoload();
        test_save();
        test_autosave();
        test_priority();
        test_readonly();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
